uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 25 ++
 rtl/uart_fifo.sv | 100 ++++++++++
 tb/tb_uart_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART FIFO.
// Default width/depth plus the occupancy-counter width function.
package uart_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Occupancy must count 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int level_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for the UART FIFO.
// One synchronous write port, one asynchronous read port, no reset.
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the accepted write word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// Synchronous UART FIFO: pointers, occupancy, status and sticky errors.
// Define UART_FIFO_FWFT_EN for first-word-fall-through read data.
module uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         rd_en,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [level_bits(DEPTH)-1:0] level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_bits(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rdata;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AF_LEVEL));
    assign almost_empty = (level <= LW'(AE_LEVEL));

    uart_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok && !flush),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Advance pointers and occupancy; flush overrides any request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_ok) - LW'(rd_ok);
        end
    end

    // Sticky errors: a fresh rejection beats err_clr; flush masks requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow && !err_clr) || (wr_en && full && !flush);
            underflow <= (underflow && !err_clr) || (rd_en && empty && !flush);
        end
    end

`ifdef UART_FIFO_FWFT_EN
    assign data_out = empty ? '0 : rdata;
`else
    // Capture the popped word; hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (flush) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= rdata;
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Directed testbench for uart_fifo (WIDTH=8, DEPTH=16).
// Honours UART_FIFO_FWFT_EN for read-data expectations.
module tb_uart_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic       flush;
    logic       err_clr;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    uart_fifo dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .flush        (flush),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       fl;
        logic       ec;
        logic [7:0] din;
        int         lvl;
        logic       emp;
        logic       ful;
        logic       af;
        logic       ae;
        logic       ov;
        logic       un;
        logic [7:0] dreg;
        logic [7:0] dfw;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        data_in = d;
        step();
        idle();
    endtask

    task automatic pop(input logic [7:0] exp, input logic w,
                       input logic [7:0] d);
`ifdef UART_FIFO_FWFT_EN
        check("dout_head", data_out, exp);
`endif
        rd_en   = 1'b1;
        wr_en   = w;
        data_in = d;
        step();
        idle();
`ifndef UART_FIFO_FWFT_EN
        check("dout_pop", data_out, exp);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"}, level, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_ae"}, almost_empty, 1);
        check({tag, "_af"}, almost_full, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_unf"}, underflow, 0);
        check({tag, "_dout"}, data_out, 0);
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h5A};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h5A};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h11};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h11};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h11};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h66};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 8'h00};

        reset_n = 1'b0;
        data_in = 8'h00;
        idle();
        step();
        step();
        check_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Table: underflow, err_clr priority, flush, 0x5A latency
        for (int i = 0; i < 13; i++) begin
            wr_en   = vt[i].wr;
            rd_en   = vt[i].rd;
            flush   = vt[i].fl;
            err_clr = vt[i].ec;
            data_in = vt[i].din;
            step();
            idle();
            check($sformatf("v%0d_level", i), level, vt[i].lvl);
            check($sformatf("v%0d_empty", i), empty, vt[i].emp);
            check($sformatf("v%0d_full", i), full, vt[i].ful);
            check($sformatf("v%0d_af", i), almost_full, vt[i].af);
            check($sformatf("v%0d_ae", i), almost_empty, vt[i].ae);
            check($sformatf("v%0d_ovf", i), overflow, vt[i].ov);
            check($sformatf("v%0d_unf", i), underflow, vt[i].un);
`ifdef UART_FIFO_FWFT_EN
            check($sformatf("v%0d_dout", i), data_out, vt[i].dfw);
`else
            check($sformatf("v%0d_dout", i), data_out, vt[i].dreg);
`endif
        end

        // Fill to full, watching thresholds
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check($sformatf("fill%0d_level", i), level, i + 1);
            check($sformatf("fill%0d_full", i), full, (i + 1) == 16);
            check($sformatf("fill%0d_af", i), almost_full, (i + 1) >= 14);
            check($sformatf("fill%0d_ae", i), almost_empty, (i + 1) <= 2);
        end

        // Overflow on full, then err_clr
        push(8'hAA);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 16);
        err_clr = 1'b1;
        step();
        idle();
        check("ovf_clr", overflow, 0);

        // Full with rd&&wr: read wins, write rejected
        pop(8'h00, 1'b1, 8'hBB);
        check("fullrw_level", level, 15);
        check("fullrw_ovf", overflow, 1);
        err_clr = 1'b1;
        step();
        idle();
        for (int i = 1; i < 16; i++) pop(8'(i), 1'b0, 8'h00);
        check("drain_empty", empty, 1);
        check("drain_level", level, 0);
        check("drain_ovf", overflow, 0);

        // Wrap-around rounds
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) push(8'(8'h20 + r * 10 + i));
            check($sformatf("wrap%0d_level", r), level, 10);
            for (int i = 0; i < 10; i++) pop(8'(8'h20 + r * 10 + i), 1'b0, 8'h00);
            check($sformatf("wrap%0d_empty", r), level, 0);
        end

        // Steady level 5 with simultaneous read/write
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        for (int k = 0; k < 20; k++) begin
            pop(8'(8'h40 + k), 1'b1, 8'(8'h45 + k));
            check($sformatf("rw%0d_level", k), level, 5);
        end
        for (int k = 20; k < 25; k++) pop(8'(8'h40 + k), 1'b0, 8'h00);
        check("rw_drain", level, 0);
        check("rw_unf", underflow, 0);

        // Flush beats write at level 7
        for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
        check("pre_flush_level", level, 7);
        flush   = 1'b1;
        wr_en   = 1'b1;
        data_in = 8'hEE;
        step();
        idle();
        check("flush_level", level, 0);
        check("flush_empty", empty, 1);
        check("flush_ovf", overflow, 0);
        check("flush_dout", data_out, 0);
        push(8'h77);
        check("post_flush_level", level, 1);
        pop(8'h77, 1'b0, 8'h00);

        // Async reset mid-burst
        rd_en = 1'b1;
        step();
        idle();
        check("pre_rst_unf", underflow, 1);
        push(8'h80);
        push(8'h81);
        wr_en   = 1'b1;
        data_in = 8'h82;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("midrst");
        idle();
        step();
        check_reset_state("midrst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        push(8'h99);
        check("post_rst_level", level, 1);
        pop(8'h99, 1'b0, 8'h00);
        check("post_rst_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
